// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit.
//   Stores: narrows and replicates register data onto a 32-bit word bus and
//   drives the matching byte enables.
//   Loads: picks the addressed byte or half out of the returned word and
//   sign- or zero-extends it.
//   Runs one handshaked bus transaction per op and holds busy so the hazard
//   unit can stall the pipe.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   start, mem_op       op request (sampled only in IDLE), op code 0..15
//   addr, wdata         byte address, store source register
//   busy, done          busy while not IDLE; done is a one-cycle completion pulse
//   rdata               extended load result, held until the next done
//   adel, ades, timeout status flags, only ever set while done=1
//   bus_*               request/ack word bus (see handshake note below)
//   dbg_state           current FSM state (0 IDLE, 1 BUS, 2 DONE)
//
// Bus handshake: bus_req rises the cycle after the op is accepted, and
// bus_we/bus_be/bus_addr/bus_wdata are stable for as long as bus_req=1.
// The transfer completes on the first cycle in which bus_req=1 and
// bus_ack=1; bus_rdata is sampled in that cycle. bus_req falls on the
// following cycle. bus_ack is ignored whenever no request is outstanding.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;

  logic        is_load, is_store, misaligned, accept;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Decode of the op presented in IDLE.
  always_comb begin
    is_load    = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
    is_store   = (mem_op >= OP_SW) && (mem_op <= OP_SB);
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = wdata;
    case (mem_op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    case (mem_op)
      OP_SH: begin
        be_new    = 4'b0011 << {addr[1], 1'b0};
        wdata_new = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
    accept = (state == S_IDLE) && start && (is_load || is_store);
  end

  // Load extraction uses the op and low address bits latched at BUS entry.
  always_comb begin
    ld_byte  = bus_rdata[{lo_q, 3'b000} +: 8];
    ld_half  = bus_rdata[{lo_q[1], 4'b0000} +: 16];
    ld_value = bus_rdata;
    case (op_q)
      OP_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_value = {16'h0000, ld_half};
      OP_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_value = {24'h000000, ld_byte};
      default: ld_value = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = misaligned ? S_DONE : S_BUS;
      S_BUS:  if (bus_ack || (wait_cnt == WAIT_LIMIT)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 8'd0;
      op_q      <= 4'd0;
      lo_q      <= 2'd0;
      rdata     <= 32'd0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && misaligned) begin
            adel <= is_load;
            ades <= is_store;
          end else if (accept) begin
            wait_cnt  <= 8'd0;
            op_q      <= mem_op;
            lo_q      <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_be    <= be_new;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= is_store ? wdata_new : 32'd0;
          end
        end
        S_BUS: begin
          // ack takes priority over an expiring wait count in the same cycle.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= ld_value;
          end else if (wait_cnt == WAIT_LIMIT) begin
            bus_req <= 1'b0;
            timeout <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          // Leaving DONE: status flags only live alongside the done pulse.
          adel    <= 1'b0;
          ades    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        busy, done, adel, ades, timeout;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .adel(adel),
    .ades(ades), .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    start  = 1'b1;
    mem_op = op;
    addr   = a;
    wdata  = wd;
    tick();
    start  = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rd);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_op = 4'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if ({busy, done, bus_req, adel, ades, timeout} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, bus_req, adel, ades, timeout}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_byte_loads();
    issue(4'd4, 32'h0000_0103, 32'h0);
    total++; if ({bus_req, bus_we, bus_be} !== 6'b1_0_1111) begin bad++; $display("FAIL lb_bus got=%b exp=101111", {bus_req, bus_we, bus_be}); end
    total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=00000100", bus_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lb_early_done got=%b exp=0", done); end
    ack_now(32'h80FF_1234);
    total++; if ({done, bus_req, adel, ades, timeout} !== 5'b10000) begin bad++; $display("FAIL lb_done got=%b exp=10000", {done, bus_req, adel, ades, timeout}); end
    total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    tick();
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL lb_idle got=%b exp=00", {done, busy}); end
    issue(4'd5, 32'h0000_0103, 32'h0);
    ack_now(32'h80FF_1234);
    total++; if (rdata !== 32'h0000_0080 || done !== 1'b1) begin bad++; $display("FAIL lbu_rdata got=%h/%b exp=00000080/1", rdata, done); end
    tick();
  endtask

  task automatic test_store_half();
    issue(4'd7, 32'h0000_0102, 32'hDEAD_BEEF);
    total++; if ({bus_req, bus_we, bus_be} !== 6'b1_1_1100) begin bad++; $display("FAIL sh_bus got=%b exp=111100", {bus_req, bus_we, bus_be}); end
    total++; if (bus_addr !== 32'h100 || bus_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_data got=%h/%h exp=00000100/beefbeef", bus_addr, bus_wdata); end
    ack_now(32'h5555_5555);
    total++; if (done !== 1'b1 || rdata !== 32'h0000_0080) begin bad++; $display("FAIL sh_rdata got=%b/%h exp=1/00000080", done, rdata); end
    tick();
  endtask

  task automatic test_misaligned();
    int req_seen;
    req_seen = 0;
    start = 1'b1; mem_op = 4'd1; addr = 32'h0000_0101;
    @(posedge clk); #1; start = 1'b0;
    if (bus_req) req_seen++;
    total++; if ({done, adel, ades, timeout} !== 4'b1100) begin bad++; $display("FAIL lw_mis got=%b exp=1100", {done, adel, ades, timeout}); end
    total++; if (rdata !== 32'h0000_0080) begin bad++; $display("FAIL lw_mis_rdata got=%h exp=00000080", rdata); end
    tick();
    if (bus_req) req_seen++;
    total++; if ({done, adel, busy} !== 3'b000) begin bad++; $display("FAIL lw_mis_clear got=%b exp=000", {done, adel, busy}); end
    issue(4'd6, 32'h0000_0102, 32'h1);
    if (bus_req) req_seen++;
    total++; if ({done, adel, ades} !== 3'b101) begin bad++; $display("FAIL sw_mis got=%b exp=101", {done, adel, ades}); end
    tick();
    total++; if (req_seen !== 0) begin bad++; $display("FAIL mis_no_bus got=%0d exp=0", req_seen); end
  endtask

  task automatic test_load_table();
    logic [3:0]  ops [6] = '{4'd2, 4'd3, 4'd2, 4'd4, 4'd5, 4'd1};
    logic [31:0] adr [6] = '{32'h2, 32'h2, 32'h0, 32'h1, 32'h0, 32'h4};
    logic [31:0] rd  [6] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF,
                             32'h1234_F0AB, 32'h1234_F0AB, 32'hCAFE_F00D};
    logic [31:0] exp [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF,
                             32'hFFFF_FFF0, 32'h0000_00AB, 32'hCAFE_F00D};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], adr[i], 32'h0);
      ack_now(rd[i]);
      total++; if (rdata !== exp[i] || done !== 1'b1) begin bad++; $display("FAIL load_%0d got=%h/%b exp=%h/1", i, rdata, done, exp[i]); end
      tick();
    end
  endtask

  task automatic test_store_table();
    logic [3:0]  ops [3] = '{4'd8, 4'd6, 4'd7};
    logic [31:0] adr [3] = '{32'h13, 32'h8, 32'h0};
    logic [3:0]  ebe [3] = '{4'b1000, 4'b1111, 4'b0011};
    logic [31:0] ewd [3] = '{32'h4444_4444, 32'h1122_3344, 32'h3344_3344};
    logic [31:0] ead [3] = '{32'h10, 32'h8, 32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], adr[i], 32'h1122_3344);
      total++; if ({bus_we, bus_be} !== {1'b1, ebe[i]} || bus_wdata !== ewd[i] || bus_addr !== ead[i]) begin
        bad++; $display("FAIL store_%0d got=%b/%h/%h exp=1%b/%h/%h", i, {bus_we, bus_be}, bus_wdata, bus_addr, ebe[i], ewd[i], ead[i]);
      end
      ack_now(32'h0);
      tick();
    end
    total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL store_rdata got=%h exp=cafef00d", rdata); end
  endtask

  task automatic test_invalid_op();
    issue(4'd0, 32'h0, 32'h0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL op_none got=%b exp=0", busy); end
    issue(4'd12, 32'h0, 32'h0);
    total++; if ({busy, bus_req} !== 2'b00) begin bad++; $display("FAIL op_12 got=%b exp=00", {busy, bus_req}); end
  endtask

  task automatic test_back_to_back();
    int rises;
    logic prev;
    rises = 0; prev = bus_req;
    start = 1'b1; mem_op = 4'd1; addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_req && !prev) rises++;
      prev = bus_req;
    end
    ack_now(32'h0BAD_F00D);
    total++; if (done !== 1'b1 || rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_done got=%b/%h exp=1/0badf00d", done, rdata); end
    tick();
    total++; if ({busy, bus_req} !== 2'b00 || rises !== 1) begin bad++; $display("FAIL b2b_idle got=%b rises=%0d exp=00 rises=1", {busy, bus_req}, rises); end
    tick();
    start = 1'b0;
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b exp=1", bus_req); end
    ack_now(32'h1);
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit seen_done;
    n = 0; seen_done = 0;
    issue(4'd1, 32'h80, 32'h0);
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (bus_req) n++;
      if (done) seen_done = 1;
      else tick();
    end
    total++; if (!seen_done || n !== 5) begin bad++; $display("FAIL to_cycles got=%0d done=%b exp=5 done=1", n, seen_done); end
    total++; if ({timeout, adel, ades, bus_req} !== 4'b1000 || rdata !== 32'h0) begin bad++; $display("FAIL to_flags got=%b/%h exp=1000/00000000", {timeout, adel, ades, bus_req}, rdata); end
    tick();
    total++; if ({timeout, done} !== 2'b00) begin bad++; $display("FAIL to_clear got=%b exp=00", {timeout, done}); end
  endtask

  task automatic test_mid_reset();
    issue(4'd1, 32'h200, 32'h0);
    #2 reset = 1'b1;
    #1;
    total++; if ({bus_req, busy} !== 2'b00) begin bad++; $display("FAIL rst_mid got=%b exp=00", {bus_req, busy}); end
    tick();
    reset = 1'b0;
    tick();
    issue(4'd1, 32'h200, 32'h0);
    ack_now(32'h1234_5678);
    total++; if (rdata !== 32'h1234_5678 || done !== 1'b1) begin bad++; $display("FAIL rst_after got=%h/%b exp=12345678/1", rdata, done); end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_byte_loads();
    test_store_half();
    test_misaligned();
    test_load_table();
    test_store_table();
    test_invalid_op();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
